// File: rtl/axis_bus_arbiter.sv
// Round-robin packet arbiter: grants one upstream packet FIFO at a time onto a
// shared AXIS bus mux and holds the grant until tlast or an idle timeout.
module axis_bus_arbiter #(
    parameter int          NUM_CH       = 12,
    parameter logic [7:0]  SEL_BASE     = 8'd128,
    parameter int          IDLE_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] fifo_pkt_rdy,
    input  logic              axis_mux_tvalid,
    input  logic              axis_mux_tlast,
    input  logic              axis_out_tready,
    output logic [7:0]        bus_sel,
    output logic [NUM_CH-1:0] fifo_tready,
    output logic              pkt_done,
    output logic              timeout_err,
    output logic              dbg_state_o
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [15:0] CNT_LIMIT = 16'(IDLE_TIMEOUT - 1);

    // Handshake: a beat is axis_mux_tvalid & axis_out_tready while in XFER;
    // fifo_tready of the granted channel mirrors axis_out_tready combinationally.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] win_q, win_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [7:0]       sel_q, sel_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             tmo_q, tmo_d;

    logic [IDX_W-1:0] rr_win;
    logic             rr_found;
    logic             beat;

    function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_CH) begin
            s = s - NUM_CH;
        end
        return IDX_W'(s);
    endfunction

    // Search upward from last+1, wrapping; the final offset revisits last itself.
    always_comb begin
        rr_found = 1'b0;
        rr_win   = last_q;
        for (int k = 1; k <= NUM_CH; k++) begin
            if (!rr_found && fifo_pkt_rdy[rr_idx(last_q, k)]) begin
                rr_found = 1'b1;
                rr_win   = rr_idx(last_q, k);
            end
        end
    end

    assign beat = (state_q == ST_XFER) && axis_mux_tvalid && axis_out_tready;

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        last_d  = last_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        tmo_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rr_found) begin
                    state_d = ST_XFER;
                    win_d   = rr_win;
                    sel_d   = SEL_BASE + 8'(rr_win);
                    cnt_d   = '0;
                end
            end
            ST_XFER: begin
                if (beat && axis_mux_tlast) begin
                    state_d = ST_IDLE;
                    sel_d   = 8'd0;
                    last_d  = win_q;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else if (beat) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LIMIT) begin
                    // A beat on the threshold cycle is handled above and wins.
                    state_d = ST_IDLE;
                    sel_d   = 8'd0;
                    last_d  = win_q;
                    cnt_d   = '0;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            win_q   <= '0;
            last_q  <= IDX_W'(NUM_CH - 1);
            sel_q   <= 8'd0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        fifo_tready = '0;
        if (!rst && state_q == ST_XFER) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (win_q == IDX_W'(i)) begin
                    fifo_tready[i] = axis_out_tready;
                end
            end
        end
    end

    assign bus_sel     = sel_q;
    assign pkt_done    = done_q;
    assign timeout_err = tmo_q;
    assign dbg_state_o = (state_q == ST_XFER);

endmodule

// File: tb/tb_axis_bus_arbiter.sv
// Directed bench for axis_bus_arbiter: grant order is checked against an
// expected-select queue, other outputs against constants at each step.
module tb_axis_bus_arbiter;

    localparam int NUM_CH       = 12;
    localparam int IDLE_TIMEOUT = 1024;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] rdy;
    logic              tvalid;
    logic              tlast;
    logic              tready;
    logic [7:0]        bus_sel;
    logic [NUM_CH-1:0] fifo_tready;
    logic              pkt_done;
    logic              timeout_err;
    logic              dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int pd_cnt   = 0;
    int to_cnt   = 0;
    int exp_pd   = 0;
    int n;

    logic [7:0]  exp_q[$];
    logic [7:0]  exp_v;
    logic [7:0]  prev_sel = 8'd0;
    logic [11:0] exp_tr;

    axis_bus_arbiter #(
        .NUM_CH(NUM_CH),
        .SEL_BASE(8'd128),
        .IDLE_TIMEOUT(IDLE_TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .fifo_pkt_rdy(rdy),
        .axis_mux_tvalid(tvalid),
        .axis_mux_tlast(tlast),
        .axis_out_tready(tready),
        .bus_sel(bus_sel),
        .fifo_tready(fifo_tready),
        .pkt_done(pkt_done),
        .timeout_err(timeout_err),
        .dbg_state_o(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Scoreboard / monitor on the inactive edge
    always @(negedge clk) begin
        if (pkt_done === 1'b1) pd_cnt++;
        if (timeout_err === 1'b1) to_cnt++;
        if (bus_sel !== 8'd0 && prev_sel === 8'd0) begin
            n_checks++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL grant_unexpected: observed=%0d required=none", bus_sel);
            end
            if (exp_q.size() != 0) begin
                exp_v = exp_q.pop_front();
                assert (bus_sel === exp_v) else begin
                    n_fail++;
                    $error("FAIL grant_order: observed=%0d required=%0d", bus_sel, exp_v);
                end
            end
        end
        prev_sel = bus_sel;
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h required=%0h", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        rdy    = '0;
        tvalid = 1'b0;
        tlast  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic last_beat();
        tvalid = 1'b1;
        tlast  = 1'b1;
        tick();
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rdy = '0; tvalid = 1'b0; tlast = 1'b0; tready = 1'b0;
        tick();
        tick();
        check("rst_bus_sel", bus_sel, 0);
        check("rst_state", dbg_state, 0);
        check("rst_pkt_done", pkt_done, 0);
        check("rst_timeout", timeout_err, 0);
        tready = 1'b1;
        #1;
        check("rst_fifo_tready", fifo_tready, 0);
        tick();
        rst = 1'b0;

        // S1: single channel, 4-beat packet
        rdy = 12'h001;
        exp_q.push_back(8'd128);
        tick();
        check("s1_grant_sel", bus_sel, 128);
        check("s1_state_xfer", dbg_state, 1);
        rdy = '0;
        tvalid = 1'b1;
        for (int b = 0; b < 4; b++) begin
            tlast = (b == 3);
            #1;
            check("s1_fifo_tready", fifo_tready, 12'h001);
            check("s1_sel_hold", bus_sel, 128);
            tick();
        end
        tvalid = 1'b0; tlast = 1'b0;
        exp_pd++;
        check("s1_sel_clear", bus_sel, 0);
        check("s1_pkt_done", pkt_done, 1);
        check("s1_state_idle", dbg_state, 0);
        check("s1_idle_tready", fifo_tready, 0);
        tick();
        check("s1_pkt_done_pulse", pkt_done, 0);
        check("s1_pkt_done_count", pd_cnt, 1);

        // S2: all requesting, 1-beat packets, grant order 0..11,0
        do_reset();
        rdy = 12'hFFF;
        for (int i = 0; i < 13; i++) exp_q.push_back(8'(128 + (i % 12)));
        for (int i = 0; i < 13; i++) begin
            tick();
            check("s2_grant", bus_sel, 128 + (i % 12));
            last_beat();
            exp_pd++;
            if (i == 12) rdy = '0;
            check("s2_idle_gap", bus_sel, 0);
        end
        tick();
        check("s2_no_grant", bus_sel, 0);
        check("s2_queue_drained", exp_q.size(), 0);

        // S3: wrap, channel 0 before channel 11 after reset
        do_reset();
        rdy = 12'h801;
        exp_q.push_back(8'd128);
        exp_q.push_back(8'd139);
        tick();
        check("s3_first", bus_sel, 128);
        last_beat();
        tick();
        check("s3_second", bus_sel, 139);
        rdy = '0;
        last_beat();
        exp_pd += 2;
        tick();

        // S4: timeout on channel 5, next search starts at 6
        do_reset();
        rdy = 12'h020;
        exp_q.push_back(8'd133);
        tick();
        check("s4_grant", bus_sel, 133);
        rdy = '0;
        n = 0;
        while (n < IDLE_TIMEOUT + 4 && timeout_err !== 1'b1) begin
            tick();
            n++;
            if (n == IDLE_TIMEOUT - 1) check("s4_sel_before_timeout", bus_sel, 133);
        end
        check("s4_timeout_latency", n, IDLE_TIMEOUT);
        check("s4_sel_clear", bus_sel, 0);
        check("s4_no_pkt_done", pkt_done, 0);
        rdy = 12'h0A1;
        exp_q.push_back(8'd135);
        tick();
        check("s4_timeout_pulse", timeout_err, 0);
        check("s4_next_from_6", bus_sel, 135);
        rdy = '0;
        // Beat on the threshold cycle must beat the timeout
        for (int i = 0; i < IDLE_TIMEOUT - 1; i++) tick();
        check("s4_sel_at_threshold", bus_sel, 135);
        tvalid = 1'b1; tlast = 1'b0;
        tick();
        tvalid = 1'b0;
        check("s4_coincide_no_timeout", timeout_err, 0);
        check("s4_coincide_sel", bus_sel, 135);
        for (int i = 0; i < 5; i++) tick();
        check("s4_still_granted", bus_sel, 135);
        last_beat();
        exp_pd++;
        check("s4_pkt_done", pkt_done, 1);
        check("s4_timeout_count", to_cnt, 1);

        // S5: tready toggling, channel 10 (last is 7)
        rdy = 12'h400;
        exp_q.push_back(8'd138);
        tick();
        check("s5_grant", bus_sel, 138);
        rdy = '0;
        tvalid = 1'b1;
        for (int s = 0; s < 5; s++) begin
            tready = ((s % 2) == 0);
            tlast  = (s == 4);
            exp_tr = tready ? 12'h400 : 12'h000;
            #1;
            check("s5_fifo_tready", fifo_tready, exp_tr);
            tick();
        end
        tvalid = 1'b0; tlast = 1'b0; tready = 1'b1;
        exp_pd++;
        check("s5_sel_clear", bus_sel, 0);
        check("s5_pkt_done", pkt_done, 1);
        check("s5_no_timeout", to_cnt, 1);

        // S6: reset on the 2nd beat of channel 3
        do_reset();
        rdy = 12'h008;
        exp_q.push_back(8'd131);
        tick();
        check("s6_grant", bus_sel, 131);
        rdy = '0;
        tvalid = 1'b1; tlast = 1'b0;
        tick();
        rst = 1'b1;
        rdy = 12'h009;
        tick();
        check("s6_sel_after_rst", bus_sel, 0);
        check("s6_no_pkt_done", pkt_done, 0);
        check("s6_tready_in_rst", fifo_tready, 0);
        check("s6_state_idle", dbg_state, 0);
        rst = 1'b0;
        tvalid = 1'b0;
        exp_q.push_back(8'd128);
        tick();
        check("s6_ch0_wins", bus_sel, 128);
        check("s6_no_pulse", pkt_done, 0);
        rdy = '0;
        last_beat();
        exp_pd++;
        tick();

        check("final_pkt_done_count", pd_cnt, exp_pd);
        check("final_timeout_count", to_cnt, 1);
        check("final_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
